// File: rtl/or1200_forw_sel_pkg.sv
// Shared select codes and tracking-entry type for the dual-issue operand-select unit.
package or1200_forw_sel_pkg;

    localparam int OR1200_SEL_WIDTH = 2;

    localparam logic [1:0] OR1200_SEL_RF      = 2'd0;
    localparam logic [1:0] OR1200_SEL_IMM     = 2'd1;
    localparam logic [1:0] OR1200_SEL_EX_FORW = 2'd2;
    localparam logic [1:0] OR1200_SEL_WB_FORW = 2'd3;

    localparam int NUM_LANES = 2;
    localparam int NUM_OPS   = 2 * NUM_LANES;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
    } trk_t;

    // r0 is hardwired zero, so it never matches a producer
    function automatic logic trk_hit(trk_t t, logic [4:0] src);
        return t.we && (src != 5'd0) && (t.addr == src);
    endfunction

endpackage

// File: rtl/or1200_forw_sel_lane.sv
// Per-operand source selection and cross-lane hazard detection.
module or1200_forw_sel_lane
    import or1200_forw_sel_pkg::*;
#(
    parameter int SEL_WIDTH = OR1200_SEL_WIDTH
) (
    input  logic [4:0]           src,
    input  logic                 use_imm,
    input  logic                 rd_valid,
    input  trk_t                 own_ex,
    input  trk_t                 own_wb,
    input  trk_t                 oth_ex,
    input  trk_t                 oth_wb,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 hazard
);

    logic own_ex_hit, own_wb_hit, oth_hit;

    assign own_ex_hit = trk_hit(own_ex, src);
    assign own_wb_hit = trk_hit(own_wb, src);
    assign oth_hit    = trk_hit(oth_ex, src) | trk_hit(oth_wb, src);

    // EX is the younger producer, so it beats WB
    always_comb begin
        sel = SEL_WIDTH'(OR1200_SEL_RF);
        if (use_imm)
            sel = SEL_WIDTH'(OR1200_SEL_IMM);
        else if (own_ex_hit)
            sel = SEL_WIDTH'(OR1200_SEL_EX_FORW);
        else if (own_wb_hit)
            sel = SEL_WIDTH'(OR1200_SEL_WB_FORW);
    end

    // No cross-lane forwarding path exists: wait until the other lane's write reaches the RF
    assign hazard = rd_valid & ~use_imm & oth_hit & ~(own_ex_hit | own_wb_hit);

endmodule

// File: rtl/or1200_forw_sel.sv
// Dual-issue operand-select and hazard unit: tracks EX/WB destinations per lane and
// produces registered operand selects plus combinational stall/split requests.
module or1200_forw_sel
    import or1200_forw_sel_pkg::*;
#(
    parameter int SEL_WIDTH = OR1200_SEL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_freeze,
    input  logic                 ex_freeze,
    input  logic                 flushpipe,
    input  logic                 id_valid,
    input  logic                 id_valid2,
    input  logic [4:0]           id_rfa_addr,
    input  logic [4:0]           id_rfb_addr,
    input  logic [4:0]           id_rfa_addr2,
    input  logic [4:0]           id_rfb_addr2,
    input  logic                 id_b_imm,
    input  logic                 id_b_imm2,
    input  logic                 id_rfwe,
    input  logic                 id_rfwe2,
    input  logic [4:0]           id_rfw_addr,
    input  logic [4:0]           id_rfw_addr2,
    output logic [SEL_WIDTH-1:0] sel_a,
    output logic [SEL_WIDTH-1:0] sel_b,
    output logic [SEL_WIDTH-1:0] sel_a2,
    output logic [SEL_WIDTH-1:0] sel_b2,
    output logic                 stall,
    output logic                 split
);

    trk_t [NUM_LANES-1:0] ex_q, wb_q;
    logic                 split_pending;

    logic [NUM_LANES-1:0]                lane_vld, lane_iss;
    logic [NUM_OPS-1:0][4:0]             op_src;
    logic [NUM_OPS-1:0]                  op_imm, op_haz, op_iss;
    logic [NUM_OPS-1:0][SEL_WIDTH-1:0]   op_sel, sel_q;
    logic                                cap, rd_l1_dst, same_dst;

    // Operand order: lane-1 A, lane-1 B, lane-2 A, lane-2 B
    assign op_src = {id_rfb_addr2, id_rfa_addr2, id_rfb_addr, id_rfa_addr};
    assign op_imm = {id_b_imm2, 1'b0, id_b_imm, 1'b0};

    // Once lane 1 of a split bundle has issued, it is no longer live in ID
    assign lane_vld = {id_valid2, id_valid & ~split_pending};

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        localparam int L = i / 2;
        or1200_forw_sel_lane #(.SEL_WIDTH(SEL_WIDTH)) u_op (
            .src      (op_src[i]),
            .use_imm  (op_imm[i]),
            .rd_valid (lane_vld[L]),
            .own_ex   (ex_q[L]),
            .own_wb   (wb_q[L]),
            .oth_ex   (ex_q[1-L]),
            .oth_wb   (wb_q[1-L]),
            .sel      (op_sel[i]),
            .hazard   (op_haz[i])
        );
        assign op_iss[i] = lane_iss[L];
    end

    assign stall = |op_haz;

    assign rd_l1_dst = id_rfwe && (id_rfw_addr != 5'd0) &&
                       ((id_rfa_addr2 == id_rfw_addr) || (!id_b_imm2 && (id_rfb_addr2 == id_rfw_addr)));
    assign same_dst  = id_rfwe && id_rfwe2 && (id_rfw_addr != 5'd0) && (id_rfw_addr == id_rfw_addr2);
    assign split     = lane_vld[0] & lane_vld[1] & (rd_l1_dst | same_dst);

    assign cap         = ~id_freeze & ~ex_freeze;
    assign lane_iss[0] = cap & ~stall & lane_vld[0];
    assign lane_iss[1] = cap & ~stall & ~split & lane_vld[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q          <= '0;
            wb_q          <= '0;
            sel_q         <= '0;
            split_pending <= 1'b0;
        end else if (flushpipe) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                ex_q[l].we <= 1'b0;
                wb_q[l].we <= 1'b0;
            end
            sel_q         <= '0;
            split_pending <= 1'b0;
        end else begin
            if (!ex_freeze) begin
                wb_q <= ex_q;
                // A frozen ID still lets EX drain, so a bubble follows it into EX
                if (id_freeze) begin
                    for (int l = 0; l < NUM_LANES; l++)
                        ex_q[l].we <= 1'b0;
                end else begin
                    ex_q[0] <= '{we: lane_iss[0] & id_rfwe,  addr: id_rfw_addr};
                    ex_q[1] <= '{we: lane_iss[1] & id_rfwe2, addr: id_rfw_addr2};
                end
            end
            if (cap) begin
                for (int i = 0; i < NUM_OPS; i++)
                    sel_q[i] <= op_iss[i] ? op_sel[i] : SEL_WIDTH'(OR1200_SEL_RF);
                if (!stall)
                    split_pending <= split;
            end
        end
    end

    assign sel_a  = sel_q[0];
    assign sel_b  = sel_q[1];
    assign sel_a2 = sel_q[2];
    assign sel_b2 = sel_q[3];

endmodule

// File: tb/tb_or1200_forw_sel.sv
// Scoreboard bench: an in-flight write list models the pipeline; a monitor compares each cycle.
module tb_or1200_forw_sel;

    typedef struct packed {
        logic            stall;
        logic            split;
        logic [3:0][1:0] sel;
    } exp_t;

    logic       clk, rst;
    logic       id_freeze, ex_freeze, flushpipe;
    logic       id_valid, id_valid2;
    logic [4:0] id_rfa_addr, id_rfb_addr, id_rfa_addr2, id_rfb_addr2;
    logic       id_b_imm, id_b_imm2, id_rfwe, id_rfwe2;
    logic [4:0] id_rfw_addr, id_rfw_addr2;
    logic [1:0] sel_a, sel_b, sel_a2, sel_b2;
    logic       stall, split;

    or1200_forw_sel dut (
        .clk(clk), .rst(rst), .id_freeze(id_freeze), .ex_freeze(ex_freeze),
        .flushpipe(flushpipe), .id_valid(id_valid), .id_valid2(id_valid2),
        .id_rfa_addr(id_rfa_addr), .id_rfb_addr(id_rfb_addr),
        .id_rfa_addr2(id_rfa_addr2), .id_rfb_addr2(id_rfb_addr2),
        .id_b_imm(id_b_imm), .id_b_imm2(id_b_imm2), .id_rfwe(id_rfwe), .id_rfwe2(id_rfwe2),
        .id_rfw_addr(id_rfw_addr), .id_rfw_addr2(id_rfw_addr2),
        .sel_a(sel_a), .sel_b(sel_b), .sel_a2(sel_a2), .sel_b2(sel_b2),
        .stall(stall), .split(split)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    bit   done = 0;

    // Reference model: list of register writes in flight (age 0 = EX, 1 = WB)
    int              inf_reg[$], inf_lane[$], inf_age[$];
    bit              m_pend;
    logic [3:0][1:0] m_sel;
    bit              last_hold;

    function automatic int own_age(int l, int s);
        int best = -1;
        for (int k = 0; k < inf_reg.size(); k++)
            if (inf_lane[k] == l && inf_reg[k] == s && (best < 0 || inf_age[k] < best))
                best = inf_age[k];
        return best;
    endfunction

    function automatic bit oth_has(int l, int s);
        for (int k = 0; k < inf_reg.size(); k++)
            if (inf_lane[k] != l && inf_reg[k] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        inf_reg.delete(); inf_lane.delete(); inf_age.delete();
        m_pend = 0;
        m_sel  = '0;
    endtask

    // Evaluate the current ID inputs against the model, push the expectation, advance the model
    task automatic eval();
        exp_t e;
        int   src[4];
        bit   imm_l[2], lv[2];
        logic [1:0] sc[4];
        bit   stl, spl, cap, i1, i2, isb, imm;
        int   l, a, s;
        int   nr[$], nl[$], na[$];
        if (!rst) model_clear();
        src = '{int'(id_rfa_addr), int'(id_rfb_addr), int'(id_rfa_addr2), int'(id_rfb_addr2)};
        imm_l = '{id_b_imm, id_b_imm2};
        lv = '{id_valid && !m_pend, id_valid2};
        stl = 0;
        for (int i = 0; i < 4; i++) begin
            l = i / 2; isb = (i % 2) == 1; s = src[i];
            imm = isb && imm_l[l];
            a = own_age(l, s);
            if (imm)                  sc[i] = 2'd1;
            else if (s != 0 && a == 0) sc[i] = 2'd2;
            else if (s != 0 && a == 1) sc[i] = 2'd3;
            else                       sc[i] = 2'd0;
            if (lv[l] && !imm && s != 0 && a < 0 && oth_has(l, s)) stl = 1;
        end
        spl = lv[0] && lv[1] && id_rfwe && id_rfw_addr != 0 &&
              (id_rfa_addr2 == id_rfw_addr || (!id_b_imm2 && id_rfb_addr2 == id_rfw_addr) ||
               (id_rfwe2 && id_rfw_addr2 == id_rfw_addr));
        e.stall = stl; e.split = spl; e.sel = m_sel;
        exp_q.push_back(e);
        last_hold = stl || spl || id_freeze || ex_freeze;
        if (!rst) return;
        if (flushpipe) begin
            model_clear();
            return;
        end
        cap = !id_freeze && !ex_freeze;
        i1  = cap && !stl && lv[0];
        i2  = cap && !stl && !spl && lv[1];
        if (cap)
            for (int i = 0; i < 4; i++) m_sel[i] = ((i < 2) ? i1 : i2) ? sc[i] : 2'd0;
        if (!ex_freeze) begin
            for (int k = 0; k < inf_reg.size(); k++)
                if (inf_age[k] == 0) begin
                    nr.push_back(inf_reg[k]); nl.push_back(inf_lane[k]); na.push_back(1);
                end
            inf_reg = nr; inf_lane = nl; inf_age = na;
        end
        if (i1 && id_rfwe)  begin inf_reg.push_back(id_rfw_addr);  inf_lane.push_back(0); inf_age.push_back(0); end
        if (i2 && id_rfwe2) begin inf_reg.push_back(id_rfw_addr2); inf_lane.push_back(1); inf_age.push_back(0); end
        if (cap && !stl) m_pend = spl;
    endtask

    task automatic drive(input bit r, input bit idf, input bit exf, input bit fl,
                         input bit va, input int ra, input int rb, input bit ia, input bit wa, input int wd,
                         input bit vb, input int ra2, input int rb2, input bit ib, input bit wb2, input int wd2);
        @(posedge clk); #1;
        rst = r; id_freeze = idf; ex_freeze = exf; flushpipe = fl;
        id_valid = va;  id_rfa_addr = 5'(ra);   id_rfb_addr = 5'(rb);   id_b_imm = ia;  id_rfwe = wa;   id_rfw_addr = 5'(wd);
        id_valid2 = vb; id_rfa_addr2 = 5'(ra2); id_rfb_addr2 = 5'(rb2); id_b_imm2 = ib; id_rfwe2 = wb2; id_rfw_addr2 = 5'(wd2);
        #1;
        eval();
    endtask

    task automatic rand_cycle();
        @(posedge clk); #1;
        rst       = ($urandom_range(0, 99) != 0);
        id_freeze = ($urandom_range(0, 9) == 0);
        ex_freeze = ($urandom_range(0, 9) == 0);
        flushpipe = ($urandom_range(0, 24) == 0);
        if (!(last_hold && $urandom_range(0, 9) < 7)) begin
            id_valid     = ($urandom_range(0, 9) < 8);
            id_valid2    = ($urandom_range(0, 9) < 8);
            id_rfa_addr  = 5'($urandom_range(0, 7));
            id_rfb_addr  = 5'($urandom_range(0, 7));
            id_rfa_addr2 = 5'($urandom_range(0, 7));
            id_rfb_addr2 = 5'($urandom_range(0, 7));
            id_b_imm     = ($urandom_range(0, 3) == 0);
            id_b_imm2    = ($urandom_range(0, 3) == 0);
            id_rfwe      = ($urandom_range(0, 9) < 6);
            id_rfwe2     = ($urandom_range(0, 9) < 6);
            id_rfw_addr  = 5'($urandom_range(0, 7));
            id_rfw_addr2 = 5'($urandom_range(0, 7));
        end
        #1;
        eval();
    endtask

    initial begin
        rst = 0; id_freeze = 0; ex_freeze = 0; flushpipe = 0;
        id_valid = 0; id_valid2 = 0; id_b_imm = 0; id_b_imm2 = 0; id_rfwe = 0; id_rfwe2 = 0;
        id_rfa_addr = 0; id_rfb_addr = 0; id_rfa_addr2 = 0; id_rfb_addr2 = 0;
        id_rfw_addr = 0; id_rfw_addr2 = 0;
        model_clear();
        last_hold = 0;
        // reset, then idle
        drive(0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
        drive(0,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
        // same-lane forwarding: EX then WB
        drive(1,0,0,0, 1,1,2,0,1,3, 0,0,0,0,0,0);
        drive(1,0,0,0, 1,3,0,0,0,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 1,3,0,0,0,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
        // cross-lane RAW: two stall cycles then RF
        drive(1,0,0,0, 0,0,0,0,0,0, 1,1,1,0,1,5);
        repeat (3) drive(1,0,0,0, 1,5,0,0,0,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
        // split bundle: lane 2 issues after split + 2 stalls
        repeat (4) drive(1,0,0,0, 1,1,2,0,1,7, 1,7,2,0,0,0);
        drive(1,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0);
        // immediate wins over forwarding; r0 never forwarded
        drive(1,0,0,0, 1,1,1,0,1,4, 0,0,0,0,0,0);
        drive(1,0,0,0, 1,0,4,1,1,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 1,0,0,0,0,0, 0,0,0,0,0,0);
        // ex_freeze hold, then flush
        drive(1,0,0,0, 1,1,1,0,1,6, 0,0,0,0,0,0);
        repeat (2) drive(1,0,1,0, 1,6,0,0,0,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 1,6,0,0,0,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 1,1,1,0,1,9, 0,0,0,0,0,0);
        drive(1,0,0,1, 0,0,0,0,0,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 1,9,9,0,0,0, 0,0,0,0,0,0);
        // reset in the middle of a stall
        drive(1,0,0,0, 0,0,0,0,0,0, 1,1,1,0,1,5);
        drive(1,0,0,0, 1,5,0,0,0,0, 0,0,0,0,0,0);
        drive(0,0,0,0, 1,5,0,0,0,0, 0,0,0,0,0,0);
        drive(1,0,0,0, 1,5,0,0,0,0, 0,0,0,0,0,0);
        repeat (3000) rand_cycle();
        done = 1;
    end

    initial begin
        exp_t e;
        logic [3:0][1:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {sel_b2, sel_a2, sel_b, sel_a};
                n_tests += 3;
                if (got !== e.sel) begin
                    n_fail++;
                    $display("FAIL sel t=%0t got %h expected %h", $time, got, e.sel);
                end
                if (stall !== e.stall) begin
                    n_fail++;
                    $display("FAIL stall t=%0t got %b expected %b", $time, stall, e.stall);
                end
                if (split !== e.split) begin
                    n_fail++;
                    $display("FAIL split t=%0t got %b expected %b", $time, split, e.split);
                end
            end else if (done) break;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout t=%0t got no completion expected done", $time);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
